// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: write-back arbiter and scoreboard for a single-write-port
// register file. The ALU and memory result producers share the write port under
// round-robin arbitration. The write is registered for one stage before it
// reaches the register file. A per-register pending bitmap stalls issue on
// RAW and WAW hazards.
// Optional feature: define SB_BYPASS_EN so that the hazard check ignores a
// register whose write-back transfers in the current cycle.
module regfile_wb_scheduler #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rs1,
  input  logic [AW-1:0]   issue_rs2,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_uses_rd,
  output logic            issue_ready,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  output logic [AW-1:0]   rd,
  output logic [XLEN-1:0] write_data,
  output logic            reg_write,
  output logic [NREG-1:0] pending,
  output logic            sb_err
);

  logic            rr_reg;
  logic [NREG-1:1] pending_reg, pending_next;
  logic [NREG-1:1] set_vec, clr_vec;
  logic [NREG-1:0] pend_full, hazard_vec;
  logic [AW-1:0]   rd_reg;
  logic [XLEN-1:0] write_data_reg;
  logic            reg_write_reg;
  logic            sb_err_reg;

  logic            xfer;
  logic            issue_fire;
  logic            orphan;
  logic [AW-1:0]   winner_rd;
  logic [XLEN-1:0] winner_data;

  // Round-robin grant: a lone requester always wins, and on a conflict rr picks the winner.
  assign alu_ready   = alu_valid & (~mem_valid | ~rr_reg);
  assign mem_ready   = mem_valid & (~alu_valid |  rr_reg);
  assign xfer        = alu_ready | mem_ready;
  assign winner_rd   = alu_ready ? alu_rd   : mem_rd;
  assign winner_data = alu_ready ? alu_data : mem_data;

  // Bit 0 of the bitmap is x0, which is never pending.
  assign pend_full = {pending_reg, 1'b0};

`ifdef SB_BYPASS_EN
  // A register that is written back this cycle no longer blocks issue.
  assign hazard_vec = {pending_reg & ~clr_vec, 1'b0};
`else
  assign hazard_vec = pend_full;
`endif

  assign issue_ready = ~(hazard_vec[issue_rs1] | hazard_vec[issue_rs2] |
                         (issue_uses_rd & hazard_vec[issue_rd]));
  assign issue_fire  = issue_valid & issue_ready;

  // Per-register set and clear terms. When both hit the same register, set wins.
  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_sb
      assign set_vec[gi] = issue_fire & issue_uses_rd & (issue_rd == AW'(gi));
      assign clr_vec[gi] = xfer & (winner_rd == AW'(gi));
    end
  endgenerate

  assign pending_next = set_vec | (pending_reg & ~clr_vec);
  assign orphan       = xfer & (winner_rd != '0) & ~pend_full[winner_rd];

  // After a grant, rr points at the requester that lost or did not ask.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          rr_reg <= 1'b0;
    else if (alu_ready) rr_reg <= 1'b1;
    else if (mem_ready) rr_reg <= 1'b0;
  end

  // Scoreboard bitmap and the sticky orphan-write flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reg <= '0;
      sb_err_reg  <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      if (orphan) sb_err_reg <= 1'b1;
    end
  end

  // Registered write port. rd and data hold between transfers, and the write strobe pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_reg         <= '0;
      write_data_reg <= '0;
      reg_write_reg  <= 1'b0;
    end else begin
      reg_write_reg <= xfer & (winner_rd != '0);
      if (xfer) begin
        rd_reg         <= winner_rd;
        write_data_reg <= winner_data;
      end
    end
  end

  assign rd         = rd_reg;
  assign write_data = write_data_reg;
  assign reg_write  = reg_write_reg;
  assign pending    = pend_full;
  assign sb_err     = sb_err_reg;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed testbench for regfile_wb_scheduler. It covers reset, a lone write-back,
// round-robin conflict, a hazard stall, x0 handling, an orphan write and a mid-run reset.
// A small register-file model in the bench consumes the write port.
module tb_regfile_wb_scheduler;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            reset;
  logic            issue_valid;
  logic [AW-1:0]   issue_rs1, issue_rs2, issue_rd;
  logic            issue_uses_rd;
  logic            issue_ready;
  logic            alu_valid, mem_valid;
  logic [AW-1:0]   alu_rd, mem_rd;
  logic [XLEN-1:0] alu_data, mem_data;
  logic            alu_ready, mem_ready;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] write_data;
  logic            reg_write;
  logic [NREG-1:0] pending;
  logic            sb_err;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] rf [0:NREG-1];

  regfile_wb_scheduler #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_uses_rd(issue_uses_rd), .issue_ready(issue_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rd(rd), .write_data(write_data), .reg_write(reg_write),
    .pending(pending), .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model driven by the DUT write port.
  always @(posedge clk) begin
    if (reg_write && rd != '0) rf[rd] <= write_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input logic [AW-1:0] d, input logic uses);
    issue_valid   = 1'b1;
    issue_rs1     = r1;
    issue_rs2     = r2;
    issue_rd      = d;
    issue_uses_rd = uses;
  endtask

  initial begin
    reset = 1'b1;
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; issue_uses_rd = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    step();
    settle();
    // Reset state
    check("rst_pending", pending, 32'h0);
    check("rst_reg_write", {31'b0, reg_write}, 32'h0);
    check("rst_rd", {27'b0, rd}, 32'h0);
    check("rst_wdata", write_data, 32'h0);
    check("rst_sb_err", {31'b0, sb_err}, 32'h0);
    check("rst_ready", {31'b0, issue_ready}, 32'h1);
    step();
    reset = 1'b0;
    step();

    // Round-robin conflict: make x2 and x4 pending, then both producers request.
    issue(0, 0, 2, 1); settle();
    check("rr_issue2_ready", {31'b0, issue_ready}, 32'h1);
    step();
    issue(0, 0, 4, 1); settle();
    check("rr_issue4_ready", {31'b0, issue_ready}, 32'h1);
    step();
    issue_valid = 0; settle();
    check("rr_pending", pending, 32'h14);
    alu_valid = 1; alu_rd = 2; alu_data = 200;
    mem_valid = 1; mem_rd = 4; mem_data = 400;
    settle();
    check("rr1_alu_ready", {31'b0, alu_ready}, 32'h1);
    check("rr1_mem_ready", {31'b0, mem_ready}, 32'h0);
    step();
    check("rr1_rd", {27'b0, rd}, 32'h2);
    check("rr1_wdata", write_data, 32'd200);
    check("rr1_reg_write", {31'b0, reg_write}, 32'h1);
    check("rr1_pending", pending, 32'h10);
    issue(0, 0, 2, 1);  // re-issue a write to x2 so the ALU's repeat write-back is expected
    settle();
    check("rr2_issue_ready", {31'b0, issue_ready}, 32'h1);
    check("rr2_alu_ready", {31'b0, alu_ready}, 32'h0);
    check("rr2_mem_ready", {31'b0, mem_ready}, 32'h1);
    step();
    issue_valid = 0;
    mem_valid = 0;
    settle();
    check("rr2_rd", {27'b0, rd}, 32'h4);
    check("rr2_wdata", write_data, 32'd400);
    check("rr2_reg_write", {31'b0, reg_write}, 32'h1);
    check("rr2_pending", pending, 32'h04);
    check("rr3_alu_ready", {31'b0, alu_ready}, 32'h1);
    step();
    alu_valid = 0;
    settle();
    check("rr3_rd", {27'b0, rd}, 32'h2);
    check("rr3_wdata", write_data, 32'd200);
    check("rr3_reg_write", {31'b0, reg_write}, 32'h1);
    check("rr3_pending", pending, 32'h0);
    check("rr3_sb_err", {31'b0, sb_err}, 32'h0);
    step();
    check("rr_idle_reg_write", {31'b0, reg_write}, 32'h0);
    check("rr_idle_rd_hold", {27'b0, rd}, 32'h2);

    // Lone ALU result to x1
    issue(0, 0, 1, 1);
    step();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 1; alu_data = 100;
    settle();
    check("alu_ready", {31'b0, alu_ready}, 32'h1);
    check("alu_mem_ready", {31'b0, mem_ready}, 32'h0);
    step();
    alu_valid = 0;
    check("alu_reg_write", {31'b0, reg_write}, 32'h1);
    check("alu_rd", {27'b0, rd}, 32'h1);
    check("alu_wdata", write_data, 32'd100);
    step();
    check("alu_rf1", rf[1], 32'd100);
    check("alu_reg_write_off", {31'b0, reg_write}, 32'h0);

    // Hazard stall: x5 in flight, then a reader of x5 waits for the MEM write-back.
    issue(0, 0, 5, 1);
    step();
    issue(5, 0, 6, 1); settle();
    check("haz_ready0", {31'b0, issue_ready}, 32'h0);
    step();
    check("haz_ready1", {31'b0, issue_ready}, 32'h0);
    mem_valid = 1; mem_rd = 5; mem_data = 555;
    settle();
    check("haz_mem_ready", {31'b0, mem_ready}, 32'h1);
`ifdef SB_BYPASS_EN
    check("haz_ready_xfer", {31'b0, issue_ready}, 32'h1);
`else
    check("haz_ready_xfer", {31'b0, issue_ready}, 32'h0);
`endif
    step();
    mem_valid = 0;
    settle();
`ifdef SB_BYPASS_EN
    check("haz_ready_after", {31'b0, issue_ready}, 32'h0);  // x6 is now pending itself
`else
    check("haz_ready_after", {31'b0, issue_ready}, 32'h1);
`endif
    step();
    issue_valid = 0;
    settle();
    check("haz_pending6", pending, 32'h40);
    alu_valid = 1; alu_rd = 6; alu_data = 66;
    step();
    alu_valid = 0;
    check("haz_clear", pending, 32'h0);
    step();

    // x0 handling
    issue(0, 0, 0, 1); settle();
    check("x0_issue_ready", {31'b0, issue_ready}, 32'h1);
    step();
    issue_valid = 0;
    check("x0_pending", pending, 32'h0);
    alu_valid = 1; alu_rd = 0; alu_data = 300;
    settle();
    check("x0_alu_ready", {31'b0, alu_ready}, 32'h1);
    step();
    alu_valid = 0;
    check("x0_reg_write", {31'b0, reg_write}, 32'h0);
    check("x0_wdata", write_data, 32'd300);
    check("x0_sb_err", {31'b0, sb_err}, 32'h0);
    step();

    // Orphan write-back to x7
    mem_valid = 1; mem_rd = 7; mem_data = 777;
    settle();
    check("orph_mem_ready", {31'b0, mem_ready}, 32'h1);
    step();
    mem_valid = 0;
    check("orph_reg_write", {31'b0, reg_write}, 32'h1);
    check("orph_rd", {27'b0, rd}, 32'h7);
    check("orph_sb_err", {31'b0, sb_err}, 32'h1);
    step();
    step();
    check("orph_sb_sticky", {31'b0, sb_err}, 32'h1);

    // Mid-run asynchronous reset with x3 pending and a write pulse in flight
    issue(0, 0, 3, 1);
    step();
    issue(0, 0, 9, 1);
    step();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 9; alu_data = 99;
    step();
    alu_valid = 0;
    check("mid_pending3", pending, 32'h08);
    check("mid_reg_write", {31'b0, reg_write}, 32'h1);
    issue(3, 0, 0, 0);
    settle();
    check("mid_ready_blocked", {31'b0, issue_ready}, 32'h0);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_pending", pending, 32'h0);
    check("mid_rst_reg_write", {31'b0, reg_write}, 32'h0);
    check("mid_rst_rd", {27'b0, rd}, 32'h0);
    check("mid_rst_wdata", write_data, 32'h0);
    check("mid_rst_sb_err", {31'b0, sb_err}, 32'h0);
    check("mid_rst_ready", {31'b0, issue_ready}, 32'h1);
    issue_valid = 0;
    step();
    reset = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler and scoreboard for the single-write-port `register_file`. It arbitrates the one write port between the ALU and load/memory result producers, drives `rd`/`write_data`/`reg_write` through a registered stage, and tracks which architectural registers have results in flight. Using that tracking, it stalls issue on RAW and WAW hazards. It sits between the decode/issue stage and `register_file` in the RISC-V core.

## Interface
- `XLEN`, 32, data width
- `NREG`, 32, architectural register count (x0 hardwired zero)
- `AW`, 5, register index width, log2(NREG)

- `clk`  in  1  core clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `issue_valid`  in  1  decode presents an instruction
- `issue_rs1`, `issue_rs2`  in  AW  source indices
- `issue_rd`  in  AW  destination index
- `issue_uses_rd`  in  1  instruction will write `issue_rd`
- `issue_ready`  out  1  no hazard; issue fires when `issue_valid & issue_ready`
- `alu_valid`, `mem_valid`  in  1  producer has a result
- `alu_rd`, `mem_rd`  in  AW  result destination
- `alu_data`, `mem_data`  in  XLEN  result value
- `alu_ready`, `mem_ready`  out  1  grant; transfer when `*_valid & *_ready`
- `rd`  out  AW  to `register_file.rd`
- `write_data`  out  XLEN  to `register_file.write_data`
- `reg_write`  out  1  to `register_file.reg_write`
- `pending`  out  NREG  scoreboard bitmap, bit 0 always 0
- `sb_err`  out  1  sticky: write-back to a non-pending nonzero register

## Operation
- **Arbitration:** round-robin with a 1-bit pointer `rr` (0 = ALU preferred).
  - Exactly one of `alu_valid`/`mem_valid` high: that requester is granted.
  - Both high: the preferred requester is granted.
  - Neither high: no grant.
  - `rr` changes only on a grant, to prefer the requester *not* granted.
  - Grants are combinational from valid and `rr`. At most one grant per cycle.
  - A granted transfer always completes; the output stage never backpressures.
- **Output stage:** on a transfer, the next edge registers `rd <= winner_rd` and `write_data <= winner_data`.
  - `reg_write <= (winner_rd != 0)`. Transfers to x0 are accepted but never write.
  - With no transfer, `reg_write <= 0`. `rd`/`write_data` hold their values.
- **Scoreboard:** `pending[NREG-1:1]` registers.
  - Set: issue fires with `issue_uses_rd` and `issue_rd != 0`, which sets `pending[issue_rd]`.
  - Clear: a write-back transfer with `winner_rd != 0` clears `pending[winner_rd]` in the same edge as the transfer.
  - Same register set and cleared in one cycle: set wins. This is only reachable with `SB_BYPASS_EN`.
  - Orphan write-back: a transfer whose `winner_rd != 0` finds `pending[winner_rd] == 0` sets `sb_err`. Only reset clears it.
- **Hazard:** `issue_ready = ~(P(issue_rs1) | P(issue_rs2) | (issue_uses_rd & P(issue_rd)))`.
  - P(i) is `pending[i]`; P(0) = 0.
  - `issue_ready` is combinational and independent of `issue_valid`.

## Timing
- Reset values: `rd`=0, `write_data`=0, `reg_write`=0, `pending`=0, `sb_err`=0, `rr`=0. `issue_ready` then evaluates to 1.
- Latency: a transfer at edge N produces `reg_write`/`rd`/`write_data` valid during cycle N+1. The `register_file` write occurs at edge N+1.
- Pending clear is visible to `issue_ready` the cycle after the transfer (no bypass).
  - A dependent instruction can issue at edge N+1.
  - It reads `register_file` after edge N+1, so it sees the new value.
- Reset asserted mid-operation: all in-flight results are dropped, the scoreboard empties, and any `reg_write` pulse is cancelled immediately (asynchronous).
- Producers must hold valid/rd/data stable until granted.

## Configuration
- `SB_BYPASS_EN`
  - **Defined:** P(i) for the hazard check excludes a register cleared by this cycle's transfer. A dependent instruction issues in the transfer cycle, so `register_file` must provide write-through for the read that follows.
  - **Undefined:** hazard uses registered `pending` only, giving one extra stall cycle versus bypass.

## Test plan
- **Reset:** assert `reset` mid-run with `pending[3]` set -> all outputs 0, `issue_ready`=1 asynchronously.
- **Lone ALU result:** `alu_valid`, `alu_rd`=1, `alu_data`=100 -> `alu_ready`=1. Next cycle `reg_write`=1, `rd`=1, `write_data`=100. `register_file` reads 100 at rs1=1.
- **Round-robin conflict:** both valid for 3 cycles, ALU rd=2/data=200 and MEM rd=4/data=400, producers holding until granted then re-presenting.
  - Grants in order: ALU, MEM, ALU.
  - `rd` sequence is 2, 4, 2 with `reg_write`=1 each cycle.
- **Hazard stall:** issue rd=5, then issue rs1=5 -> `issue_ready`=0 until MEM write-back rd=5 transfers. Ready rises the next cycle, or the same cycle with `SB_BYPASS_EN`.
- **x0 handling:** issue rd=0 then ALU write rd=0 data=300 -> `pending`=0, `alu_ready`=1, `reg_write` stays 0, reg[0] reads 0, `sb_err`=0.
- **Orphan write:** MEM write-back rd=7 with nothing pending -> `reg_write`=1, `sb_err`=1 and stays 1 until reset.
